// File: rtl/signal_types_pkg.sv
// Shared enums and helpers for the DAC playback controller.
// Channel mode and FSM state encodings are fixed so they can appear in CSR maps.
package signal_types_pkg;

    typedef enum logic [1:0] {
        DAC_MODE_CONT    = 2'd0,
        DAC_MODE_ONESHOT = 2'd1,
        DAC_MODE_REPEAT  = 2'd2,
        DAC_MODE_RSVD    = 2'd3
    } dac_play_mode_e;

    typedef enum logic [1:0] {
        DAC_ST_IDLE = 2'd0,
        DAC_ST_ARM  = 2'd1,
        DAC_ST_RUN  = 2'd2
    } dac_play_state_e;

    // True when finishing the current pass ends playback; reserved mode loops like continuous.
    function automatic logic dac_mode_terminates(input dac_play_mode_e mode,
                                                 input logic last_pass);
        case (mode)
            DAC_MODE_ONESHOT: return 1'b1;
            DAC_MODE_REPEAT:  return last_pass;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dac_play_channel.sv
// Single DAC playback channel: enable edge detect, IDLE/ARM/RUN FSM, address
// counters and a valid pipeline that lines dac_valid up with the BRAM data.
module dac_play_channel
    import signal_types_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 14,
    parameter int RD_LATENCY = 1,
    parameter int REP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic                  sync,
    input  logic                  sync_start,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH-1:0] len,
    input  logic [REP_WIDTH-1:0]  rep,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] dac,
    output logic                  dac_valid,
    output logic                  busy,
    output logic                  done
);

    dac_play_state_e       state_reg;
    dac_play_state_e       state_next;
    logic                  en_prev_reg;

    logic [ADDR_WIDTH-1:0] base_reg;
    logic [ADDR_WIDTH-1:0] len_reg;
    dac_play_mode_e        mode_reg;
    logic [REP_WIDTH-1:0]  rep_reg;
    logic [ADDR_WIDTH-1:0] offset_reg;
    logic [REP_WIDTH-1:0]  pass_reg;

    logic                  rd_en_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [RD_LATENCY-1:0] vpipe_reg;
    logic [DATA_WIDTH-1:0] dac_reg;
    logic                  dac_valid_reg;
    logic                  busy_reg;
    logic                  done_pend_reg;
    logic                  done_reg;

    logic                  start;
    logic                  last_off;
    logic                  last_pass;
    logic [REP_WIDTH-1:0]  rep_eff;
    logic                  load;
    logic                  issue;
    logic                  finish;

    assign start     = en && !en_prev_reg && (len != '0);
    assign last_off  = (offset_reg == len_reg - ADDR_WIDTH'(1));
    assign rep_eff   = (rep_reg == '0) ? REP_WIDTH'(1) : rep_reg;
    assign last_pass = (pass_reg == rep_eff - REP_WIDTH'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= DAC_ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; en low always wins over sync_start, wrap and completion.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DAC_ST_IDLE: begin
                if (start) begin
                    state_next = sync ? DAC_ST_ARM : DAC_ST_RUN;
                end
            end
            DAC_ST_ARM: begin
                if (!en) begin
                    state_next = DAC_ST_IDLE;
                end else if (sync_start) begin
                    state_next = DAC_ST_RUN;
                end
            end
            DAC_ST_RUN: begin
                if (!en) begin
                    state_next = DAC_ST_IDLE;
                end else if (last_off && dac_mode_terminates(mode_reg, last_pass)) begin
                    state_next = DAC_ST_IDLE;
                end
            end
            default: state_next = DAC_ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        load   = 1'b0;
        issue  = 1'b0;
        finish = 1'b0;
        case (state_reg)
            DAC_ST_IDLE: load = start;
            DAC_ST_RUN: begin
                issue  = en;
                finish = en && last_off && dac_mode_terminates(mode_reg, last_pass);
            end
            default: ;
        endcase
    end

    // Latched parameters and pass/offset counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_prev_reg <= 1'b0;
            base_reg    <= '0;
            len_reg     <= '0;
            mode_reg    <= DAC_MODE_CONT;
            rep_reg     <= '0;
            offset_reg  <= '0;
            pass_reg    <= '0;
        end else begin
            en_prev_reg <= en;
            if (load) begin
                base_reg   <= base;
                len_reg    <= len;
                mode_reg   <= dac_play_mode_e'(mode);
                rep_reg    <= rep;
                offset_reg <= '0;
                pass_reg   <= '0;
            end else if (issue) begin
                if (last_off) begin
                    offset_reg <= '0;
                    pass_reg   <= pass_reg + REP_WIDTH'(1);
                end else begin
                    offset_reg <= offset_reg + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // Read issue, latency-matched valid pipeline and registered DAC sample.
    // Dropping en flushes anything still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_reg     <= 1'b0;
            addr_reg      <= '0;
            vpipe_reg     <= '0;
            dac_reg       <= '0;
            dac_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_pend_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            rd_en_reg <= issue;
            addr_reg  <= issue ? (base_reg + offset_reg) : '0;
            if (!en) begin
                vpipe_reg <= '0;
            end else begin
                for (int i = RD_LATENCY - 1; i > 0; i--) begin
                    vpipe_reg[i] <= vpipe_reg[i-1];
                end
                vpipe_reg[0] <= rd_en_reg;
            end
            dac_valid_reg <= en && vpipe_reg[RD_LATENCY-1];
            dac_reg       <= (en && vpipe_reg[RD_LATENCY-1]) ? mem_data : '0;
            busy_reg      <= en && (state_reg != DAC_ST_IDLE);
            done_pend_reg <= finish;
            done_reg      <= done_pend_reg;
        end
    end

    assign mem_rd_en = rd_en_reg;
    assign mem_addr  = addr_reg;
    assign dac       = dac_reg;
    assign dac_valid = dac_valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: rtl/dac_playback_ctrl.sv
// Multi-channel DAC playback controller: one dac_play_channel per channel,
// with the top level only slicing the packed per-channel buses.
module dac_playback_ctrl
    import signal_types_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 14,
    parameter int RD_LATENCY = 1,
    parameter int REP_WIDTH  = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH-1:0]              en_i,
    input  logic [2*NUM_CH-1:0]            mode_i,
    input  logic [NUM_CH-1:0]              sync_i,
    input  logic                           sync_start_i,
    input  logic [ADDR_WIDTH*NUM_CH-1:0]   base_i,
    input  logic [ADDR_WIDTH*NUM_CH-1:0]   len_i,
    input  logic [REP_WIDTH*NUM_CH-1:0]    rep_i,
    output logic [NUM_CH-1:0]              mem_rd_en_o,
    output logic [ADDR_WIDTH*NUM_CH-1:0]   mem_addr_o,
    input  logic [DATA_WIDTH*NUM_CH-1:0]   mem_data_i,
    output logic [DATA_WIDTH*NUM_CH-1:0]   dac_o,
    output logic [NUM_CH-1:0]              dac_valid_o,
    output logic [NUM_CH-1:0]              busy_o,
    output logic [NUM_CH-1:0]              done_o
);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            dac_play_channel #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .DATA_WIDTH (DATA_WIDTH),
                .RD_LATENCY (RD_LATENCY),
                .REP_WIDTH  (REP_WIDTH)
            ) u_ch (
                .clk        (clk),
                .rst_n      (rst_n),
                .en         (en_i[gi]),
                .mode       (mode_i[gi*2 +: 2]),
                .sync       (sync_i[gi]),
                .sync_start (sync_start_i),
                .base       (base_i[gi*ADDR_WIDTH +: ADDR_WIDTH]),
                .len        (len_i[gi*ADDR_WIDTH +: ADDR_WIDTH]),
                .rep        (rep_i[gi*REP_WIDTH +: REP_WIDTH]),
                .mem_rd_en  (mem_rd_en_o[gi]),
                .mem_addr   (mem_addr_o[gi*ADDR_WIDTH +: ADDR_WIDTH]),
                .mem_data   (mem_data_i[gi*DATA_WIDTH +: DATA_WIDTH]),
                .dac        (dac_o[gi*DATA_WIDTH +: DATA_WIDTH]),
                .dac_valid  (dac_valid_o[gi]),
                .busy       (busy_o[gi]),
                .done       (done_o[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Directed bench for dac_playback_ctrl (2 channels, BRAM read latency 2).
// A small BRAM model returns a known function of the address.
module tb_dac_playback_ctrl;

    localparam int NCH = 2;
    localparam int AW  = 11;
    localparam int DW  = 14;
    localparam int LAT = 2;
    localparam int RW  = 8;

    logic                clk;
    logic                rst_n;
    logic [NCH-1:0]      en_i;
    logic [2*NCH-1:0]    mode_i;
    logic [NCH-1:0]      sync_i;
    logic                sync_start_i;
    logic [AW*NCH-1:0]   base_i;
    logic [AW*NCH-1:0]   len_i;
    logic [RW*NCH-1:0]   rep_i;
    logic [NCH-1:0]      mem_rd_en_o;
    logic [AW*NCH-1:0]   mem_addr_o;
    logic [DW*NCH-1:0]   mem_data_i;
    logic [DW*NCH-1:0]   dac_o;
    logic [NCH-1:0]      dac_valid_o;
    logic [NCH-1:0]      busy_o;
    logic [NCH-1:0]      done_o;

    int n_checks = 0;
    int n_errors = 0;

    dac_playback_ctrl #(
        .NUM_CH     (NCH),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_LATENCY (LAT),
        .REP_WIDTH  (RW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en_i),
        .mode_i       (mode_i),
        .sync_i       (sync_i),
        .sync_start_i (sync_start_i),
        .base_i       (base_i),
        .len_i        (len_i),
        .rep_i        (rep_i),
        .mem_rd_en_o  (mem_rd_en_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_i   (mem_data_i),
        .dac_o        (dac_o),
        .dac_valid_o  (dac_valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] sample_of(input logic [AW-1:0] a, input int c);
        logic [31:0] t;
        t = 32'(a) * 5 + 7 + c * 100;
        return t[DW-1:0];
    endfunction

    // BRAM model with two cycles of read latency
    logic [DW-1:0] s1 [NCH];
    logic [DW-1:0] s2 [NCH];
    for (genvar gi = 0; gi < NCH; gi++) begin : g_mem
        always @(posedge clk) begin
            s1[gi] <= sample_of(mem_addr_o[gi*AW +: AW], gi);
            s2[gi] <= s1[gi];
        end
        assign mem_data_i[gi*DW +: DW] = s2[gi];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int c, input int b, input int l, input int m,
                          input int r, input logic s);
        base_i[c*AW +: AW] = AW'(b);
        len_i[c*AW +: AW]  = AW'(l);
        mode_i[c*2 +: 2]   = 2'(m);
        rep_i[c*RW +: RW]  = RW'(r);
        sync_i[c]          = s;
    endtask

    function automatic logic [AW-1:0] addr_of(input int c);
        return mem_addr_o[c*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] dac_of(input int c);
        return dac_o[c*DW +: DW];
    endfunction

    initial begin
        int n_addr;
        int n_done;
        rst_n = 1'b0;
        en_i = '0; mode_i = '0; sync_i = '0; sync_start_i = 1'b0;
        base_i = '0; len_i = '0; rep_i = '0;

        // Reset state
        tick(); tick();
        chk("rst_rden", 32'(mem_rd_en_o), 0);
        chk("rst_addr", 32'(mem_addr_o), 0);
        chk("rst_dac", 32'(dac_o), 0);
        chk("rst_valid", 32'(dac_valid_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        rst_n = 1'b1;
        tick();

        // One-shot: base 16, len 4
        set_ch(0, 16, 4, 1, 0, 1'b0);
        en_i[0] = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("os_rden", mem_rd_en_o[0], (k <= 4));
            if (k <= 4) chk("os_addr", addr_of(0), 15 + k);
            chk("os_done", done_o[0], (k == 5));
            chk("os_busy", busy_o[0], (k <= 4));
            chk("os_valid", dac_valid_o[0], (k >= 4 && k <= 7));
            if (k >= 4 && k <= 7) chk("os_dac", dac_of(0), sample_of(AW'(16 + k - 4), 0));
            chk("os_ch1_quiet", mem_rd_en_o[1], 0);
        end
        en_i[0] = 1'b0;
        tick();

        // Continuous: base 2045, len 3; CSR changes during RUN must be ignored
        set_ch(0, 2045, 3, 0, 0, 1'b0);
        en_i[0] = 1'b1;
        tick();
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 2) set_ch(0, 5, 7, 1, 0, 1'b0);
            chk("cont_rden", mem_rd_en_o[0], 1);
            chk("cont_addr", addr_of(0), 2045 + (k - 1) % 3);
            chk("cont_busy", busy_o[0], 1);
            chk("cont_done", done_o[0], 0);
            if (k >= 4) begin
                chk("cont_valid", dac_valid_o[0], 1);
                chk("cont_dac", dac_of(0), sample_of(AW'(2045 + (k - 4) % 3), 0));
            end
        end

        // Abort mid-pass
        en_i[0] = 1'b0;
        tick();
        chk("abort_rden", mem_rd_en_o[0], 0);
        chk("abort_valid", dac_valid_o[0], 0);
        chk("abort_busy", busy_o[0], 0);
        chk("abort_done", done_o[0], 0);
        tick();
        chk("abort_valid2", dac_valid_o[0], 0);
        chk("abort_done2", done_o[0], 0);
        tick();

        // Repeat rep=3, len=2 across the address-space wrap
        set_ch(0, 2047, 2, 2, 3, 1'b0);
        en_i[0] = 1'b1;
        n_addr = 0; n_done = 0;
        tick();
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (mem_rd_en_o[0]) begin
                chk("rep3_addr", addr_of(0), (n_addr % 2 == 0) ? 2047 : 0);
                n_addr++;
            end
            if (done_o[0]) n_done++;
        end
        chk("rep3_naddr", n_addr, 6);
        chk("rep3_ndone", n_done, 1);
        en_i[0] = 1'b0;
        tick();

        // Repeat with rep=0 behaves as a single pass
        set_ch(0, 2047, 2, 2, 0, 1'b0);
        en_i[0] = 1'b1;
        n_addr = 0; n_done = 0;
        tick();
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (mem_rd_en_o[0]) n_addr++;
            if (done_o[0]) n_done++;
        end
        chk("rep0_naddr", n_addr, 2);
        chk("rep0_ndone", n_done, 1);
        en_i[0] = 1'b0;
        tick();

        // Sync start: two channels armed on different cycles, released together
        set_ch(0, 100, 2, 0, 0, 1'b1);
        set_ch(1, 200, 3, 0, 0, 1'b1);
        en_i = 2'b01;
        tick();
        en_i = 2'b11;
        tick();
        tick();
        chk("arm_busy", 32'(busy_o), 3);
        chk("arm_rden", 32'(mem_rd_en_o), 0);
        sync_start_i = 1'b1;
        tick();
        sync_start_i = 1'b0;
        chk("sync_rden_s", 32'(mem_rd_en_o), 0);
        tick();
        chk("sync_rden", 32'(mem_rd_en_o), 3);
        chk("sync_addr0", addr_of(0), 100);
        chk("sync_addr1", addr_of(1), 200);
        tick();
        chk("sync_addr0_b", addr_of(0), 101);
        chk("sync_addr1_b", addr_of(1), 201);
        tick();
        chk("sync_addr0_c", addr_of(0), 100);
        chk("sync_addr1_c", addr_of(1), 202);
        en_i = 2'b00;
        tick();
        chk("sync_off_busy", 32'(busy_o), 0);
        chk("sync_off_rden", 32'(mem_rd_en_o), 0);
        tick();

        // en rising together with sync_start only arms; next pulse releases
        en_i[0] = 1'b1;
        sync_start_i = 1'b1;
        tick();
        sync_start_i = 1'b0;
        tick();
        tick();
        chk("simul_rden", mem_rd_en_o[0], 0);
        chk("simul_busy", busy_o[0], 1);
        sync_start_i = 1'b1;
        tick();
        sync_start_i = 1'b0;
        tick();
        chk("simul_rel_rden", mem_rd_en_o[0], 1);
        chk("simul_rel_addr", addr_of(0), 100);
        en_i[0] = 1'b0;
        tick();

        // len=0 never starts
        set_ch(1, 300, 0, 1, 0, 1'b0);
        en_i[1] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("len0_rden", mem_rd_en_o[1], 0);
            chk("len0_busy", busy_o[1], 0);
            chk("len0_valid", dac_valid_o[1], 0);
            chk("len0_done", done_o[1], 0);
        end
        en_i[1] = 1'b0;
        tick();

        // Asynchronous reset during RUN, then restart from base
        set_ch(0, 16, 4, 0, 0, 1'b0);
        en_i[0] = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        chk("pre_rst_valid", dac_valid_o[0], 1);
        #2;
        rst_n = 1'b0;
        en_i[0] = 1'b0;
        #1;
        chk("arst_rden", 32'(mem_rd_en_o), 0);
        chk("arst_addr", 32'(mem_addr_o), 0);
        chk("arst_dac", 32'(dac_o), 0);
        chk("arst_valid", 32'(dac_valid_o), 0);
        chk("arst_busy", 32'(busy_o), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        en_i[0] = 1'b1;
        tick();
        tick();
        chk("restart_rden", mem_rd_en_o[0], 1);
        chk("restart_addr", addr_of(0), 16);
        tick();
        chk("restart_addr2", addr_of(0), 17);
        en_i[0] = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
